// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: per-item price and stock, three coin values,
// capped credit, cancel/refund, and change paid as a train of unit-coin pulses.
module vending_machine_multi #(
  parameter int unsigned                  CREDIT_W    = 8,
  parameter int unsigned                  N_ITEMS     = 4,
  parameter int unsigned                  SEL_W       = 2,
  parameter logic [N_ITEMS*CREDIT_W-1:0]  PRICES      = {8'd10, 8'd25, 8'd20, 8'd15},
  parameter int unsigned                  COIN_A      = 5,
  parameter int unsigned                  COIN_B      = 10,
  parameter int unsigned                  COIN_C      = 25,
  parameter int unsigned                  CHANGE_UNIT = 5,
  parameter int unsigned                  MAX_CREDIT  = 50,
  parameter int unsigned                  STOCK_W     = 4,
  parameter int unsigned                  STOCK_INIT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                product,
  output logic [SEL_W-1:0]    product_id,
  output logic                change,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                insufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [SEL_W-1:0]    productId_q;
  logic                product_q;
  logic                change_q;
  logic                reject_q;
  logic                soldOut_q;
  logic                insuff_q;
  logic                busy_q;

  logic [CREDIT_W-1:0] coinVal;
  logic [CREDIT_W:0]   creditSum;
  logic [CREDIT_W-1:0] selPrice;
  logic [STOCK_W-1:0]  selStock;
  logic                selInRange;

  // Decode the coin value and look up price/stock of the selected item.
  always_comb begin
    coinVal    = '0;
    selPrice   = '0;
    selStock   = '0;
    selInRange = 1'b0;
    case (coin)
      2'b01:   coinVal = CREDIT_W'(COIN_A);
      2'b10:   coinVal = CREDIT_W'(COIN_B);
      2'b11:   coinVal = CREDIT_W'(COIN_C);
      default: coinVal = '0;
    endcase
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        selInRange = 1'b1;
        selPrice   = PRICES[i*CREDIT_W +: CREDIT_W];
        selStock   = stock_q[i];
      end
    end
  end

  // One extra bit so an over-cap sum is detected instead of wrapping.
  assign creditSum = {1'b0, credit_q} + {1'b0, coinVal};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      productId_q <= '0;
      product_q   <= 1'b0;
      change_q    <= 1'b0;
      reject_q    <= 1'b0;
      soldOut_q   <= 1'b0;
      insuff_q    <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      product_q <= 1'b0;
      change_q  <= 1'b0;
      reject_q  <= 1'b0;
      soldOut_q <= 1'b0;
      insuff_q  <= 1'b0;
      busy_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coin != 2'b00) begin
            credit_q <= coinVal;
            state_q  <= CREDIT;
          end else if (sel_valid) begin
            insuff_q <= 1'b1;
          end
        end
        CREDIT: begin
          if (cancel) begin
            state_q  <= CHANGE;
            change_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (coin != 2'b00) begin
            if (creditSum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
              credit_q <= creditSum[CREDIT_W-1:0];
            end else begin
              reject_q <= 1'b1;
            end
          end else if (sel_valid && selInRange) begin
            if (selStock == '0) begin
              soldOut_q <= 1'b1;
            end else if (credit_q < selPrice) begin
              insuff_q <= 1'b1;
            end else begin
              credit_q    <= credit_q - selPrice;
              productId_q <= sel;
              product_q   <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= VEND;
              for (int unsigned i = 0; i < N_ITEMS; i++) begin
                if (sel == SEL_W'(i)) begin
                  stock_q[i] <= stock_q[i] - STOCK_W'(1);
                end
              end
            end
          end
        end
        VEND: begin
          reject_q <= (coin != 2'b00);
          if (credit_q != '0) begin
            state_q  <= CHANGE;
            change_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        CHANGE: begin
          // The pulse shown this cycle accounts for the unit removed at this edge.
          reject_q <= (coin != 2'b00);
          credit_q <= credit_q - CREDIT_W'(CHANGE_UNIT);
          if (credit_q == CREDIT_W'(CHANGE_UNIT)) begin
            state_q <= IDLE;
          end else begin
            change_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign product      = product_q;
  assign product_id   = productId_q;
  assign change       = change_q;
  assign coin_reject  = reject_q;
  assign sold_out     = soldOut_q;
  assign insufficient = insuff_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level model of the vending rules.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       product;
  logic [1:0] product_id;
  logic       change;
  logic       coin_reject;
  logic       sold_out;
  logic       insufficient;
  logic [7:0] credit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model state: credit, stock, last item, pending vend cycle, change pulses left.
  int   mCredit;
  int   mStock [4];
  int   mPid;
  bit   mVend;
  int   mChangeLeft;
  bit   eReject, eSold, eInsuf;

  int nProd, nChange, nReject, nSold, nInsuf, nBusy;

  vending_machine_multi dut (
    .clk          (clk),
    .rst          (rst),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .product      (product),
    .product_id   (product_id),
    .change       (change),
    .coin_reject  (coin_reject),
    .sold_out     (sold_out),
    .insufficient (insufficient),
    .credit       (credit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic int coinValue(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int priceOf(input int item);
    case (item)
      0:       return 15;
      1:       return 20;
      2:       return 25;
      default: return 10;
    endcase
  endfunction

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mCredit     = 0;
    mPid        = 0;
    mVend       = 0;
    mChangeLeft = 0;
    eReject     = 0;
    eSold       = 0;
    eInsuf      = 0;
    for (int i = 0; i < 4; i++) mStock[i] = 2;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    int v;
    v       = coinValue(coin);
    eReject = 0;
    eSold   = 0;
    eInsuf  = 0;
    if (mVend) begin
      eReject     = (v != 0);
      mVend       = 0;
      mChangeLeft = mCredit / 5;
    end else if (mChangeLeft > 0) begin
      eReject = (v != 0);
      mCredit -= 5;
      mChangeLeft--;
    end else if (mCredit == 0) begin
      if (v != 0) mCredit = v;
      else if (sel_valid) eInsuf = 1;
    end else begin
      if (cancel) begin
        mChangeLeft = mCredit / 5;
      end else if (v != 0) begin
        if (mCredit + v <= 50) mCredit += v;
        else eReject = 1;
      end else if (sel_valid) begin
        if (mStock[sel] == 0) eSold = 1;
        else if (mCredit < priceOf(int'(sel))) eInsuf = 1;
        else begin
          mCredit -= priceOf(int'(sel));
          mStock[sel]--;
          mPid  = int'(sel);
          mVend = 1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("product",      int'(product),      int'(mVend));
    checkValue("product_id",   int'(product_id),   mPid);
    checkValue("change",       int'(change),       int'(mChangeLeft > 0));
    checkValue("coin_reject",  int'(coin_reject),  int'(eReject));
    checkValue("sold_out",     int'(sold_out),     int'(eSold));
    checkValue("insufficient", int'(insufficient), int'(eInsuf));
    checkValue("credit",       int'(credit),       mCredit);
    checkValue("busy",         int'(busy),         int'(mVend || mChangeLeft > 0));
    nProd   += int'(product);
    nChange += int'(change);
    nReject += int'(coin_reject);
    nSold   += int'(sold_out);
    nInsuf  += int'(insufficient);
    nBusy   += int'(busy);
  endtask

  task automatic clearCounts();
    nProd = 0; nChange = 0; nReject = 0; nSold = 0; nInsuf = 0; nBusy = 0;
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic sv, input logic [1:0] s,
                               input logic cn);
    @(negedge clk);
    coin      = c;
    sel_valid = sv;
    sel       = s;
    cancel    = cn;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; coin = 2'b00; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
    clearCounts();
    modelReset();
    #1;
    checkOutput();
    repeat (2) @(negedge clk);
    checkOutput();
    rst = 1'b0;

    // Exact pay for item 0 (price 15).
    clearCounts();
    applyStimulus(2'b01, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b10, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b00, 1'b1, 2'd0, 1'b0);
    checkValue("t1 product_id", int'(product_id), 0);
    idle(3);
    checkValue("t1 products", nProd, 1);
    checkValue("t1 change pulses", nChange, 0);
    checkValue("t1 credit", int'(credit), 0);

    // Overpay for item 3 (price 10) with 25.
    clearCounts();
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b00, 1'b1, 2'd3, 1'b0);
    checkValue("t2 credit after vend", int'(credit), 15);
    idle(6);
    checkValue("t2 products", nProd, 1);
    checkValue("t2 change pulses", nChange, 3);
    checkValue("t2 busy cycles", nBusy, 4);

    // Credit cap then full refund.
    clearCounts();
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b01, 1'b0, 2'd0, 1'b0);
    checkValue("t3 reject", int'(coin_reject), 1);
    checkValue("t3 credit capped", int'(credit), 50);
    applyStimulus(2'b00, 1'b0, 2'd0, 1'b1);
    idle(12);
    checkValue("t3 refund pulses", nChange, 10);
    checkValue("t3 credit", int'(credit), 0);

    // Drain item 2, then sold-out and insufficient.
    clearCounts();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
      applyStimulus(2'b00, 1'b1, 2'd2, 1'b0);
      idle(2);
    end
    checkValue("t4 vends", nProd, 2);
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b00, 1'b1, 2'd2, 1'b0);
    checkValue("t4 sold_out", int'(sold_out), 1);
    checkValue("t4 credit kept", int'(credit), 25);
    applyStimulus(2'b00, 1'b0, 2'd0, 1'b1);
    idle(7);
    applyStimulus(2'b10, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b00, 1'b1, 2'd1, 1'b0);
    checkValue("t4 insufficient", int'(insufficient), 1);
    applyStimulus(2'b00, 1'b0, 2'd0, 1'b1);
    idle(4);

    // Cancel wins over coin and selection in the same cycle.
    clearCounts();
    applyStimulus(2'b10, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b01, 1'b1, 2'd3, 1'b1);
    idle(4);
    checkValue("t5 refund pulses", nChange, 2);
    checkValue("t5 products", nProd, 0);
    checkValue("t5 rejects", nReject, 0);
    clearCounts();
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b00, 1'b0, 2'd0, 1'b1);
    applyStimulus(2'b01, 1'b0, 2'd0, 1'b0);
    idle(6);
    checkValue("t5 reject in change", nReject, 1);

    // Asynchronous reset in the middle of a refund.
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b00, 1'b0, 2'd0, 1'b1);
    idle(2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkValue("t6 credit on reset", int'(credit), 0);
    checkValue("t6 change on reset", int'(change), 0);
    checkValue("t6 busy on reset", int'(busy), 0);
    modelReset();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b01, 1'b0, 2'd0, 1'b0);
    checkValue("t6 coin after reset", int'(credit), 5);
    applyStimulus(2'b00, 1'b0, 2'd0, 1'b1);
    idle(2);
    clearCounts();
    applyStimulus(2'b11, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'b00, 1'b1, 2'd2, 1'b0);
    checkValue("t6 stock restored", nProd, 1);
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] c;
      logic       sv, cn;
      c  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      sv = ($urandom_range(0, 3) == 0);
      cn = ($urandom_range(0, 19) == 0);
      applyStimulus(c, sv, 2'($urandom_range(0, 3)), cn);
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised next-generation vending controller: N_ITEMS selectable products, each with its own price and stock counter.
- Three coin denominations, credit capped at a maximum.
- Cancel/refund supported.
- Change is paid out as a serial train of unit-coin pulses.
- Sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

Parameters:
- CREDIT_W, 8, width of credit register and price fields
- N_ITEMS, 4, number of selectable products (2..8)
- SEL_W, 2, width of item select; must satisfy 2**SEL_W >= N_ITEMS
- PRICES, {8'd10,8'd25,8'd20,8'd15}, packed N_ITEMS*CREDIT_W; item i price = PRICES[i*CREDIT_W +: CREDIT_W]
- COIN_A, 5, value of coin code 01
- COIN_B, 10, value of coin code 10
- COIN_C, 25, value of coin code 11
- CHANGE_UNIT, 5, value of one change pulse; all coin values and prices are multiples of it
- MAX_CREDIT, 50, credit ceiling
- STOCK_W, 4, stock counter width
- STOCK_INIT, 2, per-item stock after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- coin  in  2  00 none, 01 COIN_A, 10 COIN_B, 11 COIN_C; sampled every cycle, one coin per cycle
- sel_valid  in  1  selection strobe, one cycle
- sel  in  SEL_W  item index, valid with sel_valid
- cancel  in  1  refund request, one cycle
- product  out  1  one-cycle dispense pulse
- product_id  out  SEL_W  item dispensed; valid while product=1, holds last value otherwise
- change  out  1  one pulse per CHANGE_UNIT returned
- coin_reject  out  1  one-cycle pulse: coin not accepted, physically returned
- sold_out  out  1  one-cycle pulse: selected item has stock 0
- insufficient  out  1  one-cycle pulse: credit < price of selected item
- credit  out  CREDIT_W  current credit
- busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset (async, rst=1): state IDLE, credit=0, all stock counters=STOCK_INIT, product_id=0. All pulse outputs 0, busy=0. Reset mid-vend or mid-change abandons the operation; credit is lost.
- All outputs are registered. Status pulses appear the cycle after the causing input.
- States: IDLE, CREDIT, VEND, CHANGE.
- IDLE:
  - coin!=00 → credit=value, go to CREDIT.
  - sel_valid → insufficient pulse.
  - cancel ignored.
- CREDIT:
  - Priority: cancel > coin > sel_valid. Lower-priority inputs in the same cycle are ignored, with no pulse.
  - cancel: go to CHANGE (credit>0 always holds here).
  - coin: if credit+value <= MAX_CREDIT, credit += value. Otherwise coin_reject and credit unchanged. Compute the sum at CREDIT_W+1 bits so there is no wrap.
  - sel_valid with sel >= N_ITEMS: ignored.
  - sel_valid with stock[sel]==0: sold_out.
  - sel_valid with credit < price: insufficient.
  - sel_valid otherwise: credit -= price, stock[sel] -= 1, latch product_id=sel, go to VEND.
  - sold_out takes precedence over insufficient.
- VEND (exactly 1 cycle):
  - product=1.
  - Next state: CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each cycle: change=1, credit -= CHANGE_UNIT.
  - When credit reaches 0, go to IDLE on that edge. N units of change produce exactly N consecutive pulses.
- Coins arriving in VEND or CHANGE → coin_reject; sel_valid and cancel are ignored.
- Stock never underflows. Stock is not refilled except by reset.

Test Plan:
- Exact pay, item0 (15): coin 01 then 10, then sel_valid sel=0 → product=1 with product_id=0 next cycle; no change pulses; credit=0; stock0=1; back to IDLE.
- Overpay, item3 (10): coin 11, then sel=3 → product pulse, then exactly 3 consecutive change pulses; credit steps 15→10→5→0; busy high for 4 cycles.
- Credit cap: coins 11, 11 (credit 50), then 01 → coin_reject pulse, credit stays 50. Then cancel → 10 change pulses, credit 0.
- Stock and price errors:
  - Buy item2 (25) twice with coin 11 each time → two vends.
  - Third attempt with coin 11, sel=2 → sold_out, credit stays 25.
  - sel=1 with 10 credit → insufficient.
- Priority: in CREDIT with credit 10, assert coin=01, sel_valid sel=3 and cancel in the same cycle → refund path only, 2 change pulses, no product, no coin_reject. Separately, a coin during CHANGE → coin_reject.
- Async reset: assert rst mid-CHANGE, between clock edges → credit, change and busy go 0 immediately; stock returns to 2 for all items; after release, coin 01 is accepted normally.
